// File: rtl/pcie_link_pkg.sv
// pcie_link_pkg: shared link-state encoding, LTSSM codes and CSR word map for the link monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcie_link_pkg;

  typedef enum logic [1:0] {
    DOWN     = 2'd0,
    TRAINING = 2'd1,
    UP       = 2'd2,
    RECOVERY = 2'd3
  } link_state_t;

  localparam logic [4:0] LTSSM_DETECT_QUIET  = 5'h00;
  localparam logic [4:0] LTSSM_DETECT_ACTIVE = 5'h01;
  localparam logic [4:0] LTSSM_RCVR_LOCK     = 5'h0C;
  localparam logic [4:0] LTSSM_RCVR_IDLE     = 5'h0E;
  localparam logic [4:0] LTSSM_L0            = 5'h0F;

  localparam logic [2:0] CSR_STATUS   = 3'd0;
  localparam logic [2:0] CSR_UPTIME   = 3'd1;
  localparam logic [2:0] CSR_RECOVERY = 3'd2;
  localparam logic [2:0] CSR_LINKDOWN = 3'd3;
  localparam logic [2:0] CSR_CORR_ERR = 3'd4;

  // Recovery.RcvrLock .. Recovery.Idle
  function automatic logic ltssm_in_recovery(input logic [4:0] s);
    return (s >= LTSSM_RCVR_LOCK) && (s <= LTSSM_RCVR_IDLE);
  endfunction

endpackage

// File: rtl/pcie_sat_counter.sv
// pcie_sat_counter: event counter that sticks at all-ones; synchronous clear beats increment.
// Latency: count updates on the clock edge after inc/clr.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), inc, clr, cnt[CNT_W-1:0].
module pcie_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pcie_link_monitor.sv
// pcie_link_monitor: folds HIP LTSSM/DL status into a DOWN/TRAINING/UP/RECOVERY FSM with uptime and event counters, readable over Avalon-MM.
// Latency: link_up/link_event registered one cycle after the causing input; avs_readdata valid exactly one cycle after avs_read.
// Backpressure: none; the CSR slave has no waitrequest and takes one access per cycle.
// Ports: clk_clk, reset_reset_n; status_hip_* inputs from the hard IP; avs_* CSR slave; link_up, link_event status outputs.
module pcie_link_monitor
  import pcie_link_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [4:0]  status_hip_ltssmstate,
  input  logic        status_hip_dlup_exit,
  input  logic [3:0]  status_hip_lane_act,
  input  logic        status_hip_ev1us,
  input  logic        status_hip_derr_cor_ext_rcv,
  input  logic        status_hip_derr_cor_ext_rpl,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        link_up,
  output logic        link_event
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  link_state_t      state, state_nxt;
  logic [DEB_W-1:0] deb_cnt;
  logic [3:0]       width;
  logic [31:0]      uptime_us;
  logic [CNT_W-1:0] recovery_cnt, linkdown_cnt, corr_err_cnt;
  logic             l0, enter_down, rec_inc, down_inc, corr_inc, cnt_clr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign l0           = (status_hip_ltssmstate == LTSSM_L0);
  assign enter_down   = (state != DOWN) && (state_nxt == DOWN);
  assign rec_inc      = (state == UP) && (state_nxt == RECOVERY);
  assign down_inc     = ((state == UP) || (state == RECOVERY)) && (state_nxt == DOWN);
  assign corr_inc     = status_hip_derr_cor_ext_rcv | status_hip_derr_cor_ext_rpl;
  assign cnt_clr      = avs_write && (avs_address == CSR_STATUS) && avs_writedata[0];
  assign unused_wdata = ^avs_writedata[31:1];

  always_comb begin
    state_nxt = state;
    case (state)
      DOWN:     if ((status_hip_ltssmstate != LTSSM_DETECT_QUIET) &&
                    (status_hip_ltssmstate != LTSSM_DETECT_ACTIVE)) state_nxt = TRAINING;
      // deb_cnt holds the L0 cycles already seen, so this is the last one needed
      TRAINING: if (l0 && (deb_cnt == DEB_LAST)) state_nxt = UP;
      UP:       if (ltssm_in_recovery(status_hip_ltssmstate)) state_nxt = RECOVERY;
      RECOVERY: if (l0) state_nxt = UP;
      default:  state_nxt = DOWN;
    endcase
    // Loss of link overrides whatever the LTSSM decode above chose
    if ((state != DOWN) &&
        ((status_hip_ltssmstate == LTSSM_DETECT_QUIET) || !status_hip_dlup_exit))
      state_nxt = DOWN;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= DOWN;
      deb_cnt    <= '0;
      width      <= '0;
      uptime_us  <= '0;
      link_up    <= 1'b0;
      link_event <= 1'b0;
    end else begin
      state      <= state_nxt;
      link_event <= (state_nxt != state);
      link_up    <= (state_nxt == UP) || (state_nxt == RECOVERY);

      if ((state == TRAINING) && l0 && (state_nxt == TRAINING)) deb_cnt <= deb_cnt + 1'b1;
      else                                                       deb_cnt <= '0;

      // Width reflects the lane count negotiated at initial training, not after recovery
      if (enter_down)                                   width <= '0;
      else if ((state == TRAINING) && (state_nxt == UP)) width <= status_hip_lane_act;

      if (enter_down)                       uptime_us <= '0;
      else if (status_hip_ev1us && link_up) uptime_us <= uptime_us + 32'd1;
    end
  end

  pcie_sat_counter #(.CNT_W(CNT_W)) u_recovery_cnt (
    .clk(clk_clk), .rst_n(reset_reset_n), .inc(rec_inc), .clr(cnt_clr), .cnt(recovery_cnt));

  pcie_sat_counter #(.CNT_W(CNT_W)) u_linkdown_cnt (
    .clk(clk_clk), .rst_n(reset_reset_n), .inc(down_inc), .clr(cnt_clr), .cnt(linkdown_cnt));

  pcie_sat_counter #(.CNT_W(CNT_W)) u_corr_err_cnt (
    .clk(clk_clk), .rst_n(reset_reset_n), .inc(corr_inc), .clr(cnt_clr), .cnt(corr_err_cnt));

  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      CSR_STATUS:   rd_mux = {21'd0, state, width, status_hip_ltssmstate};
      CSR_UPTIME:   rd_mux = uptime_us;
      CSR_RECOVERY: rd_mux = 32'(recovery_cnt);
      CSR_LINKDOWN: rd_mux = 32'(linkdown_cnt);
      CSR_CORR_ERR: rd_mux = 32'(corr_err_cnt);
      default:      rd_mux = 32'd0;
    endcase
  end

  // Sampled before any same-cycle clear lands, so a read alongside a clear sees old values
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pcie_link_monitor.sv
module tb_pcie_link_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ltssm;
  logic        dlup_exit;
  logic [3:0]  lane_act;
  logic        ev1us, cor_rcv, cor_rpl;
  logic [2:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata_s;
  logic        rdv, rdv_s, lu, lu_s, le, le_s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ev_cnt = 0;
  int ev_cnt_s = 0;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic [31:0] d_s;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0] ltssm;
    logic       dlup;
    int         n;
    logic       exp_lu;
    int         exp_ev;
  } row_t;
  row_t tbl[15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Main instance at default widths
  pcie_link_monitor dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .status_hip_ltssmstate(ltssm), .status_hip_dlup_exit(dlup_exit),
    .status_hip_lane_act(lane_act), .status_hip_ev1us(ev1us),
    .status_hip_derr_cor_ext_rcv(cor_rcv), .status_hip_derr_cor_ext_rpl(cor_rpl),
    .avs_address(addr), .avs_read(rd), .avs_write(wr), .avs_writedata(wdata),
    .avs_readdata(rdata), .avs_readdatavalid(rdv),
    .link_up(lu), .link_event(le));

  // Narrow-counter twin driven identically, so saturation is reachable quickly
  pcie_link_monitor #(.DEBOUNCE_CYCLES(16), .CNT_W(2)) dut_s (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .status_hip_ltssmstate(ltssm), .status_hip_dlup_exit(dlup_exit),
    .status_hip_lane_act(lane_act), .status_hip_ev1us(ev1us),
    .status_hip_derr_cor_ext_rcv(cor_rcv), .status_hip_derr_cor_ext_rpl(cor_rpl),
    .avs_address(addr), .avs_read(rd), .avs_write(wr), .avs_writedata(wdata),
    .avs_readdata(rdata_s), .avs_readdatavalid(rdv_s),
    .link_up(lu_s), .link_event(le_s));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (le)   ev_cnt++;
    if (le_s) ev_cnt_s++;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] e, input bit wr_too = 1'b0);
    exp_t x;
    x.cyc = cyc;
    x.d   = e;
    x.d_s = (a >= 3'd2 && a <= 3'd4 && e > 32'd3) ? 32'd3 : e;
    sb.push_back(x);
    addr = a; rd = 1'b1; wr = wr_too; wdata = 32'd1;
    tick();
    rd = 1'b0; wr = 1'b0; wdata = 32'd0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; wr = 1'b1; wdata = d;
    tick();
    wr = 1'b0; wdata = 32'd0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int e0, e0s;
      e0 = ev_cnt; e0s = ev_cnt_s;
      ltssm = tbl[i].ltssm; dlup_exit = tbl[i].dlup;
      repeat (tbl[i].n) tick();
      check($sformatf("row%0d_link_up", i), lu, tbl[i].exp_lu);
      check($sformatf("row%0d_link_up_s", i), lu_s, tbl[i].exp_lu);
      check($sformatf("row%0d_events", i), ev_cnt - e0, tbl[i].exp_ev);
      check($sformatf("row%0d_events_s", i), ev_cnt_s - e0s, tbl[i].exp_ev);
    end
    dlup_exit = 1'b1;
  endtask

  // Read scoreboard: every valid must match the oldest outstanding read, one cycle later
  always @(negedge clk) begin
    exp_t x;
    if (rdv || rdv_s) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdv_unexpected: readdatavalid=%0b/%0b with no read outstanding", rdv, rdv_s);
      end else begin
        x = sb.pop_front();
        check("rdv_pair", {30'd0, rdv, rdv_s}, 32'd3);
        check("rd_latency", cyc, x.cyc + 1);
        check("rdata", rdata, x.d);
        check("rdata_s", rdata_s, x.d_s);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    //            ltssm  dlup  n   lu    ev
    tbl[0]  = '{5'h02, 1'b1, 5,  1'b0, 1};  // DOWN -> TRAINING
    tbl[1]  = '{5'h0F, 1'b1, 15, 1'b0, 0};  // 15 L0 cycles: still training
    tbl[2]  = '{5'h0F, 1'b1, 1,  1'b1, 1};  // 16th -> UP
    tbl[3]  = '{5'h0F, 1'b1, 3,  1'b1, 0};
    tbl[4]  = '{5'h0D, 1'b1, 3,  1'b1, 1};  // UP -> RECOVERY
    tbl[5]  = '{5'h0F, 1'b1, 1,  1'b1, 1};  // RECOVERY -> UP, no debounce
    tbl[6]  = '{5'h0C, 1'b0, 1,  1'b0, 1};  // dlup_exit beats recovery entry
    tbl[7]  = '{5'h00, 1'b1, 2,  1'b0, 0};
    tbl[8]  = '{5'h02, 1'b1, 1,  1'b0, 1};
    tbl[9]  = '{5'h0F, 1'b1, 16, 1'b1, 1};
    tbl[10] = '{5'h02, 1'b1, 1,  1'b0, 1};
    tbl[11] = '{5'h0F, 1'b1, 10, 1'b0, 0};
    tbl[12] = '{5'h02, 1'b1, 1,  1'b0, 0};  // non-L0 restarts debounce
    tbl[13] = '{5'h0F, 1'b1, 15, 1'b0, 0};
    tbl[14] = '{5'h0F, 1'b1, 1,  1'b1, 1};

    rst_n = 1'b0; ltssm = 5'h00; dlup_exit = 1'b1; lane_act = 4'h4;
    ev1us = 1'b0; cor_rcv = 1'b0; cor_rpl = 1'b0;
    addr = 3'd0; rd = 1'b0; wr = 1'b0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_link_up", lu, 0);
    check("rst_link_event", le, 0);
    check("rst_rdv", rdv, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) do_read(3'(a), 32'd0);

    // Training debounce and a recovery round-trip
    run_rows(0, 5);
    do_read(3'd2, 32'd1);
    do_read(3'd0, 32'h48F);
    do_read(3'd3, 32'd0);

    // Uptime and the unmapped words
    for (int i = 0; i < 10; i++) begin
      ev1us = 1'b1; tick();
      ev1us = 1'b0; tick();
    end
    do_read(3'd1, 32'd10);
    do_read(3'd6, 32'd0);
    do_read(3'd5, 32'd0);
    do_read(3'd7, 32'd0);

    // Correctable errors: both inputs high in one cycle count once
    cor_rcv = 1'b1; tick();
    cor_rcv = 1'b0; cor_rpl = 1'b1; tick();
    cor_rcv = 1'b1; tick();
    cor_rcv = 1'b0; cor_rpl = 1'b0; tick();
    cor_rcv = 1'b1; cor_rpl = 1'b1; tick();
    cor_rcv = 1'b0; cor_rpl = 1'b0;
    do_read(3'd4, 32'd4);

    // Writes other than addr0 bit0 have no effect
    do_write(3'd0, 32'h2);
    do_write(3'd4, 32'h1);
    do_write(3'd2, 32'h1);
    do_read(3'd4, 32'd4);
    do_read(3'd2, 32'd1);
    do_write(3'd0, 32'h1);
    do_read(3'd2, 32'd0);
    do_read(3'd4, 32'd0);
    do_read(3'd1, 32'd10);

    // Link drop with LTSSM in recovery range
    run_rows(6, 7);
    do_read(3'd3, 32'd1);
    do_read(3'd2, 32'd0);
    do_read(3'd1, 32'd0);
    do_read(3'd0, 32'd0);
    repeat (3) begin
      ev1us = 1'b1; tick();
      ev1us = 1'b0; tick();
    end
    do_read(3'd1, 32'd0);

    // Retrain, then width must survive recovery and a lane_act change
    run_rows(8, 9);
    do_read(3'd0, 32'h48F);
    ltssm = 5'h0D; tick();
    lane_act = 4'h2; tick();
    check("recov_link_up", lu, 1);
    do_read(3'd0, 32'h68D);
    ltssm = 5'h0F; tick();
    do_read(3'd0, 32'h48F);
    for (int i = 0; i < 4; i++) begin
      ltssm = 5'h0D; tick();
      check($sformatf("sat_loop%0d_link_up", i), lu, 1);
      ltssm = 5'h0F; tick();
    end
    do_read(3'd2, 32'd5);

    // Clear in the same cycle as recovery and error increments
    ltssm = 5'h0D; cor_rcv = 1'b1; addr = 3'd0; wr = 1'b1; wdata = 32'd1;
    tick();
    wr = 1'b0; wdata = 32'd0; cor_rcv = 1'b0; ltssm = 5'h0F;
    tick();
    do_read(3'd2, 32'd0);
    do_read(3'd4, 32'd0);

    // Read together with a clear
    ltssm = 5'h0D; tick();
    ltssm = 5'h0F; tick();
    do_read(3'd0, 32'h48F, 1'b1);
    do_read(3'd2, 32'd0);

    // Reset during TRAINING with a read about to be captured
    ltssm = 5'h00; tick();
    ltssm = 5'h02; tick();
    addr = 3'd0; rd = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_link_up", lu, 0);
    check("midrst_link_event", le, 0);
    check("midrst_rdv", rdv, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_rdata_s", rdata_s, 0);
    tick();
    rd = 1'b0;
    tick();
    check("inrst_rdv", rdv, 0);
    check("inrst_link_event", le, 0);
    ltssm = 5'h00;
    rst_n = 1'b1;
    tick();
    tick();
    check("postrst_link_up", lu, 0);
    check("postrst_link_event", le, 0);
    do_read(3'd3, 32'd0);
    do_read(3'd1, 32'd0);

    // Debounce restarts on a non-L0 cycle; width latches new lane count
    lane_act = 4'h8;
    run_rows(10, 14);
    do_read(3'd0, 32'h50F);

    tick();
    tick();
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_link_monitor.md
PCIE_LINK_MONITOR -- requirements
Module: pcie_link_monitor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, which sets the consecutive L0 cycles required before the link is declared up.
REQ-002 SHALL have parameter CNT_W, default 16, which sets the width of the saturating event counters.
REQ-003 clk_clk  in  1  sole clock, pld_clk domain.
REQ-004 reset_reset_n  in  1  asynchronous active-low reset.
REQ-005 status_hip_ltssmstate  in  5  HIP LTSSM state.
REQ-006 status_hip_dlup_exit  in  1  active-low 1-cycle pulse when the data link leaves DL_Active.
REQ-007 status_hip_lane_act  in  4  negotiated lane count.
REQ-008 status_hip_ev1us  in  1  1-cycle pulse every 1 us.
REQ-009 status_hip_derr_cor_ext_rcv, status_hip_derr_cor_ext_rpl  in  1 each  correctable-error pulses.
REQ-010 avs_address  in  3  word address of the CSR slave.
REQ-011 avs_read, avs_write  in  1 each  CSR strobes.
REQ-012 avs_writedata  in  32  CSR write data.
REQ-013 avs_readdata  out  32  registered read data.
REQ-014 avs_readdatavalid  out  1  read-data qualifier.
REQ-015 link_up  out  1  high in states UP and RECOVERY.
REQ-016 link_event  out  1  1-cycle pulse on any link-state change.

Function
REQ-017 SHALL implement FSM states DOWN, TRAINING, UP, RECOVERY.
REQ-018 DOWN->TRAINING SHALL occur when ltssm is not in {0x00, 0x01}.
REQ-019 TRAINING->UP SHALL occur when ltssm==0x0F has held for DEBOUNCE_CYCLES consecutive cycles; the debounce counter clears on any non-L0 cycle.
REQ-020 UP->RECOVERY SHALL occur when ltssm is in 0x0C..0x0E; RECOVERY->UP SHALL occur on ltssm==0x0F with no debounce.
REQ-021 Any state except DOWN SHALL go to DOWN when ltssm==0x00 or dlup_exit==0; this has priority over every other transition.
REQ-022 link_event SHALL pulse the cycle after every state register change.
REQ-023 The width register SHALL latch lane_act on entry to UP from TRAINING only; it holds through RECOVERY and clears to 0 on entry to DOWN.
REQ-024 uptime_us (32 bit) SHALL increment on ev1us while link_up, wrap 0xFFFFFFFF->0, and clear on entry to DOWN.
REQ-025 recovery_cnt SHALL increment on each UP->RECOVERY transition; linkdown_cnt on each UP/RECOVERY->DOWN transition; corr_err_cnt once per cycle in which either derr_cor_ext input is high.
REQ-026 All three event counters SHALL saturate at all-ones.
REQ-027 CSR word map: 0 {21'b0, state[1:0], width[3:0], ltssm[4:0]}; 1 uptime_us; 2 recovery_cnt; 3 linkdown_cnt; 4 corr_err_cnt; 5..7 SHALL read 0. Counters are zero-extended.
REQ-028 A read SHALL return avs_readdata with avs_readdatavalid high exactly 1 cycle after avs_read; there is no waitrequest.
REQ-029 A write to address 0 with avs_writedata[0]=1 SHALL clear counters 2..4 next cycle; clear wins over a same-cycle increment; all other writes are ignored.
REQ-030 A simultaneous read and write SHALL return the pre-clear value.

Reset
REQ-031 Reset SHALL put the FSM in DOWN and set all counters, width, debounce count, avs_readdata, avs_readdatavalid, link_up and link_event to 0.
REQ-032 A reset asserted mid-operation SHALL take effect immediately, abort any pending read, and suppress link_event.

Structure
REQ-033 Package pcie_link_pkg SHALL hold the FSM state enum, the LTSSM constants (DETECT_QUIET=0x00, DETECT_ACTIVE=0x01, RCVR_LOCK=0x0C, RCVR_IDLE=0x0E, L0=0x0F) and the CSR address constants.
REQ-034 Sub-module pcie_sat_counter (CNT_W, inc, clr) SHALL be instantiated three times; everything else is flat.

Verification
REQ-035 Hold ltssm 0x02 for 5 cycles, then 0x0F for 15 cycles -> state stays TRAINING; 16th cycle -> UP, link_event pulses once, width = lane_act (4'h4).
REQ-036 In UP, drive 0x0D for 3 cycles then 0x0F -> RECOVERY then UP with no debounce; recovery_cnt=1; link_up stays 1.
REQ-037 In UP, pulse dlup_exit=0 while ltssm=0x0C -> DOWN, linkdown_cnt=1, recovery_cnt=0, uptime and width = 0.
REQ-038 Preload recovery_cnt to 0xFFFF (CNT_W=16) and force another recovery -> stays 0xFFFF; write addr0 data 1 in the same cycle as an increment -> reads 0.
REQ-039 Issue 10 ev1us pulses in UP then read addr1 -> readdata 10 one cycle after read; read addr6 -> 0.
REQ-040 Assert reset during TRAINING with a read in flight -> readdatavalid is never asserted; all outputs are 0.
